inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Synthesizable, parametrised instruction player for the nexys3 calculator datapath.
- Buffers a program of instruction words, then issues them one at a time over a valid/ready handshake to the core's instruction input.
- Replaces manual switch-plus-btnS single stepping.
- Adds run, single-step and loop modes, a programmable inter-issue gap, overflow detection and abort.

Parameters:
- WIDTH, 8, instruction word width in bits.
- DEPTH, 16, program buffer entries (power of two, ≥2).
- AW, 4, pointer width (log2 DEPTH).
- GAP_CYCLES, 0, idle cycles inserted after each accepted instruction (0 = back-to-back).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  append wr_data to buffer.
- wr_data  in  WIDTH  instruction word to append.
- clr  in  1  empty buffer, clear overflow.
- start  in  1  begin playback (pulse).
- step  in  1  advance one instruction in STEP mode (pulse).
- abort  in  1  stop playback.
- mode  in  2  00 RUN, 01 STEP, 10 LOOP, 11 treated as RUN.
- inst_rdy  in  1  consumer accepts inst_wd.
- inst_vld  out  1  inst_wd valid.
- inst_wd  out  WIDTH  current instruction word.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse at end of playback.
- count  out  AW+1  number of buffered instructions.
- ptr  out  AW  index of current/next instruction.
- overflow  out  1  sticky: write attempted while full.

Behaviour:
- Reset (async, any time, including mid-playback):
  - state = IDLE; count, ptr = 0.
  - inst_vld, busy, done, overflow = 0; inst_wd = 0.
  - Buffer contents are don't-care.
- Buffer writes:
  - Accepted only in IDLE. At count == DEPTH the write is dropped and overflow is set.
  - wr_en while busy is ignored without setting overflow.
  - clr in IDLE sets count = 0 and overflow = 0; clr while busy is ignored.
  - clr and wr_en in the same cycle: clr wins, the write is dropped.
- Mode is latched at start; changes to mode during playback have no effect.
- States:
  - IDLE:
    - start with count > 0: ptr = 0, go to ISSUE.
    - start with count == 0: done pulses next cycle, state stays IDLE.
    - start has priority over wr_en/clr in the same cycle.
  - ISSUE:
    - inst_vld = 1; inst_wd = buf[ptr], registered and stable while inst_vld is high.
    - Held until inst_rdy is sampled high; a handshake is inst_vld & inst_rdy on a rising edge.
    - On handshake, last entry (ptr == count-1):
      - LOOP: ptr = 0 and continue.
      - Otherwise: go to FINISH.
    - On handshake, not last: ptr = ptr+1.
    - Next state after a non-final handshake: GAP if GAP_CYCLES > 0; else HOLD in STEP mode; else ISSUE (vld stays high, back-to-back).
  - GAP:
    - inst_vld = 0; counts GAP_CYCLES cycles.
    - Then HOLD in STEP mode, else ISSUE.
  - HOLD:
    - inst_vld = 0; waits for step, then ISSUE on the next cycle.
    - A step pulse in any other state is ignored; pulses are not queued.
  - FINISH:
    - done = 1 for exactly one cycle; inst_vld = 0; then IDLE.
    - ptr retains the last index.
- abort in any non-IDLE state:
  - Next cycle: IDLE, inst_vld = 0, no done pulse.
  - A handshake in the abort cycle still counts as accepted.
  - abort has priority over all other transitions.
- Latency:
  - start sampled at edge N gives inst_vld high after edge N+1.
  - The final handshake at edge M gives done high for the cycle after M.
- count never exceeds DEPTH; ptr wraps only via LOOP, never past count-1.

Test Plan:
- Load 0x04, 0x00, 0x13, 0x92; mode RUN; GAP_CYCLES = 3; inst_rdy tied 1; start at cycle 0.
  - Expect inst_vld single-cycle pulses at cycles 1, 5, 9, 13 with words 0x04, 0x00, 0x13, 0x92.
  - Expect done at cycle 14 and busy low from cycle 15.
- Same program, inst_rdy low for 5 cycles at each issue.
  - Expect each word held stable with inst_vld high until rdy rises, with no word skipped or repeated.
- STEP mode, GAP_CYCLES = 0.
  - Expect first word issued after start, then inst_vld low until each step pulse.
  - A step during ISSUE is ignored.
  - done follows the 4th handshake.
- LOOP mode with 2 words 0xC0, 0x41.
  - Expect sequence 0xC0, 0x41, 0xC0, 0x41, ...
  - Assert abort mid-GAP: next cycle busy = 0, inst_vld = 0, no done pulse.
- Write DEPTH+1 words.
  - Expect count = DEPTH and overflow = 1.
  - clr: count = 0, overflow = 0.
  - start with count = 0: done pulses once, busy stays 0.
- Assert rst during ISSUE with inst_vld high.
  - Expect all outputs 0 asynchronously, before the next clock edge.
  - After rst release, start replays from ptr 0 once the buffer is reloaded.

Source files
------------

// File: rtl/inst_sequencer.sv
// Program buffer plus player that issues buffered instruction words to the core over vld/rdy.
// Latency: start -> inst_vld after two edges; final handshake -> done in the next cycle.
// Backpressure: inst_wd holds with inst_vld high until inst_rdy; writes are accepted only while idle.
module inst_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    input  logic             start,
    input  logic             step,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             inst_rdy,
    output logic             inst_vld,
    output logic [WIDTH-1:0] inst_wd,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count,
    output logic [AW-1:0]    ptr,
    output logic             overflow
);

    localparam int            GW       = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_GAP,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           after_hs;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count_q;
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_nxt;
    logic [1:0]       mode_q;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] wd_q;
    logic             ovf_q;
    logic             empty_done_q;
    logic             step_mode;
    logic             loop_mode;
    logic             is_last;
    logic             gap_done;
    logic             idle_cmd;
    logic             wr_ok;
    logic             load_wd;

    assign step_mode = (mode_q == 2'b01);
    assign loop_mode = (mode_q == 2'b10);
    assign is_last   = ({1'b0, ptr_q} == count_q - (AW+1)'(1));
    assign gap_done  = (gap_cnt == GAP_LAST);

    // Buffer maintenance only while idle and not starting; start outranks wr_en/clr.
    assign idle_cmd = (state == S_IDLE) && !start;
    assign wr_ok    = idle_cmd && !clr && wr_en && (count_q != FULL);

    // The word register is refreshed on every edge that enters ISSUE or completes a back-to-back handshake.
    assign load_wd  = (state_nxt == S_ISSUE) && ((state != S_ISSUE) || inst_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ptr_q <= '0;
        end else begin
            state <= state_nxt;
            ptr_q <= ptr_nxt;
        end
    end

    always_comb begin
        after_hs = S_ISSUE;
        if (GAP_CYCLES > 0)
            after_hs = S_GAP;
        else if (step_mode)
            after_hs = S_HOLD;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr_q;
        case (state)
            S_IDLE: begin
                if (start && (count_q != '0)) begin
                    state_nxt = S_LOAD;
                    ptr_nxt   = '0;
                end
            end
            S_LOAD: state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (inst_rdy) begin
                    if (is_last && !loop_mode) begin
                        state_nxt = S_FINISH;
                    end else begin
                        ptr_nxt   = is_last ? '0 : ptr_q + AW'(1);
                        state_nxt = after_hs;
                    end
                end
            end
            S_GAP: begin
                if (gap_done)
                    state_nxt = step_mode ? S_HOLD : S_ISSUE;
            end
            S_HOLD: begin
                if (step)
                    state_nxt = S_ISSUE;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // Abort outranks everything; the pointer is left where it was.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            ptr_nxt   = ptr_q;
        end
    end

    always_comb begin
        inst_vld = (state == S_ISSUE);
        busy     = (state != S_IDLE);
        done     = (state == S_FINISH) || empty_done_q;
        inst_wd  = wd_q;
        count    = count_q;
        ptr      = ptr_q;
        overflow = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q         <= '0;
            mode_q       <= 2'b00;
            gap_cnt      <= '0;
            empty_done_q <= 1'b0;
        end else begin
            empty_done_q <= (state == S_IDLE) && start && (count_q == '0);
            if ((state == S_IDLE) && start)
                mode_q <= mode;
            if (load_wd)
                wd_q <= mem[ptr_nxt];
            if (state == S_GAP)
                gap_cnt <= gap_cnt + GW'(1);
            else
                gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (idle_cmd) begin
            if (clr) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else if (wr_en) begin
                if (count_q == FULL)
                    ovf_q <= 1'b1;
                else
                    count_q <= count_q + (AW+1)'(1);
            end
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[count_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench: dut3 has a 3-cycle gap, dut0 issues back-to-back; both share control inputs.
module tb_inst_sequencer;

    logic       clk = 1'b0;
    logic       rst, wr_en, clr, start, step, abort, rdy3, rdy0;
    logic [7:0] wr_data;
    logic [1:0] mode;

    logic       vld3, busy3, done3, ovf3;
    logic [7:0] wd3;
    logic [4:0] count3;
    logic [3:0] ptr3;
    logic       vld0, busy0, done0, ovf0;
    logic [7:0] wd0;
    logic [4:0] count0;
    logic [3:0] ptr0;

    logic [7:0] prog [4];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    inst_sequencer #(.WIDTH(8), .DEPTH(16), .AW(4), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
        .start(start), .step(step), .abort(abort), .mode(mode), .inst_rdy(rdy3),
        .inst_vld(vld3), .inst_wd(wd3), .busy(busy3), .done(done3),
        .count(count3), .ptr(ptr3), .overflow(ovf3)
    );

    inst_sequencer #(.WIDTH(8), .DEPTH(16), .AW(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
        .start(start), .step(step), .abort(abort), .mode(mode), .inst_rdy(rdy0),
        .inst_vld(vld0), .inst_wd(wd0), .busy(busy0), .done(done0),
        .count(count0), .ptr(ptr0), .overflow(ovf0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle_clear();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = prog[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (vld3 !== 1'b0)   begin n_err++; $display("FAIL reset_vld got %b want 0", vld3); end
        n_cmp++; if (busy3 !== 1'b0)  begin n_err++; $display("FAIL reset_busy got %b want 0", busy3); end
        n_cmp++; if (done3 !== 1'b0)  begin n_err++; $display("FAIL reset_done got %b want 0", done3); end
        n_cmp++; if (count3 !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count3); end
        n_cmp++; if (ptr3 !== 4'd0)   begin n_err++; $display("FAIL reset_ptr got %0d want 0", ptr3); end
        n_cmp++; if (ovf3 !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf3); end
        n_cmp++; if (wd3 !== 8'h00)   begin n_err++; $display("FAIL reset_wd got %h want 00", wd3); end
    endtask

    task automatic test_run_gap();
        logic exp_vld, exp_done, exp_busy;
        go_idle_clear();
        prog[0] = 8'h04; prog[1] = 8'h00; prog[2] = 8'h13; prog[3] = 8'h92;
        load_prog(4);
        n_cmp++; if (count3 !== 5'd4) begin n_err++; $display("FAIL run_count got %0d want 4", count3); end
        mode = 2'b00; rdy3 = 1'b1; rdy0 = 1'b1;
        pulse_start();
        n_cmp++; if (vld3 !== 1'b0 || busy3 !== 1'b1) begin
            n_err++; $display("FAIL run_c0 vld=%b busy=%b want vld=0 busy=1", vld3, busy3);
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_vld  = (c == 1 || c == 5 || c == 9 || c == 13);
            exp_done = (c == 14);
            exp_busy = (c <= 14);
            n_cmp++; if (vld3 !== exp_vld)   begin n_err++; $display("FAIL run_vld c%0d got %b want %b", c, vld3, exp_vld); end
            n_cmp++; if (done3 !== exp_done) begin n_err++; $display("FAIL run_done c%0d got %b want %b", c, done3, exp_done); end
            n_cmp++; if (busy3 !== exp_busy) begin n_err++; $display("FAIL run_busy c%0d got %b want %b", c, busy3, exp_busy); end
            if (exp_vld) begin
                n_cmp++; if (wd3 !== prog[(c-1)/4]) begin
                    n_err++; $display("FAIL run_wd c%0d got %h want %h", c, wd3, prog[(c-1)/4]);
                end
            end
            if (c == 14) begin
                n_cmp++; if (ptr3 !== 4'd3) begin n_err++; $display("FAIL run_ptr_last got %0d want 3", ptr3); end
            end
            // Mode changes mid-playback must not turn the run into single-step.
            if (c == 3) mode = 2'b01;
        end
        mode = 2'b00;
    endtask

    task automatic test_stall();
        int w;
        go_idle_clear();
        load_prog(4);
        mode = 2'b00; rdy3 = 1'b0; rdy0 = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (vld3 !== 1'b1 && w < 10) begin tick(); w++; end
            n_cmp++; if (vld3 !== 1'b1) begin n_err++; $display("FAIL stall_wait word%0d vld got %b want 1", i, vld3); end
            for (int k = 0; k < 5; k++) begin
                n_cmp++; if (vld3 !== 1'b1 || wd3 !== prog[i]) begin
                    n_err++; $display("FAIL stall_hold word%0d k%0d vld=%b wd=%h want vld=1 wd=%h", i, k, vld3, wd3, prog[i]);
                end
                tick();
            end
            rdy3 = 1'b1;
            n_cmp++; if (vld3 !== 1'b1 || wd3 !== prog[i]) begin
                n_err++; $display("FAIL stall_hs word%0d vld=%b wd=%h want vld=1 wd=%h", i, vld3, wd3, prog[i]);
            end
            tick();
            rdy3 = 1'b0;
            if (i < 3) begin
                n_cmp++; if (vld3 !== 1'b0 || done3 !== 1'b0) begin
                    n_err++; $display("FAIL stall_after word%0d vld=%b done=%b want 0 0", i, vld3, done3);
                end
            end else begin
                n_cmp++; if (done3 !== 1'b1 || vld3 !== 1'b0) begin
                    n_err++; $display("FAIL stall_done done=%b vld=%b want 1 0", done3, vld3);
                end
            end
        end
        tick();
        n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL stall_idle busy got %b want 0", busy3); end
        rdy3 = 1'b1;
    endtask

    task automatic test_step();
        go_idle_clear();
        load_prog(4);
        mode = 2'b01; rdy0 = 1'b0; rdy3 = 1'b1;
        pulse_start();
        mode = 2'b00;
        n_cmp++; if (busy0 !== 1'b1 || vld0 !== 1'b0) begin
            n_err++; $display("FAIL step_c0 busy=%b vld=%b want 1 0", busy0, vld0);
        end
        tick();
        n_cmp++; if (vld0 !== 1'b1 || wd0 !== 8'h04) begin
            n_err++; $display("FAIL step_first vld=%b wd=%h want 1 04", vld0, wd0);
        end
        step = 1'b1; tick(); step = 1'b0;
        n_cmp++; if (vld0 !== 1'b1 || wd0 !== 8'h04) begin
            n_err++; $display("FAIL step_in_issue vld=%b wd=%h want 1 04", vld0, wd0);
        end
        rdy0 = 1'b1;
        tick();
        n_cmp++; if (vld0 !== 1'b0 || busy0 !== 1'b1) begin
            n_err++; $display("FAIL step_hold vld=%b busy=%b want 0 1", vld0, busy0);
        end
        tick();
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL step_not_queued vld got %b want 0", vld0); end
        for (int i = 1; i < 4; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            n_cmp++; if (vld0 !== 1'b1 || wd0 !== prog[i]) begin
                n_err++; $display("FAIL step_issue word%0d vld=%b wd=%h want 1 %h", i, vld0, wd0, prog[i]);
            end
            tick();
            n_cmp++; if (vld0 !== 1'b0 || done0 !== (i == 3)) begin
                n_err++; $display("FAIL step_after word%0d vld=%b done=%b want 0 %b", i, vld0, done0, (i == 3));
            end
        end
        tick();
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_err++; $display("FAIL step_end busy=%b done=%b want 0 0", busy0, done0);
        end
    endtask

    task automatic test_loop_abort();
        logic       exp_vld;
        logic [7:0] exp_wd;
        go_idle_clear();
        prog[0] = 8'hC0; prog[1] = 8'h41;
        load_prog(2);
        mode = 2'b10; rdy3 = 1'b1; rdy0 = 1'b1;
        pulse_start();
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_vld = (c == 1 || c == 5 || c == 9 || c == 13);
            exp_wd  = (((c - 1) / 4) % 2 == 1) ? 8'h41 : 8'hC0;
            n_cmp++; if (vld3 !== exp_vld) begin n_err++; $display("FAIL loop_vld c%0d got %b want %b", c, vld3, exp_vld); end
            n_cmp++; if (done3 !== 1'b0)   begin n_err++; $display("FAIL loop_done c%0d got %b want 0", c, done3); end
            if (exp_vld) begin
                n_cmp++; if (wd3 !== exp_wd) begin n_err++; $display("FAIL loop_wd c%0d got %h want %h", c, wd3, exp_wd); end
            end
        end
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++; if (busy3 !== 1'b0 || vld3 !== 1'b0 || done3 !== 1'b0) begin
            n_err++; $display("FAIL abort_gap busy=%b vld=%b done=%b want 0 0 0", busy3, vld3, done3);
        end
        tick();
        n_cmp++; if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            n_err++; $display("FAIL abort_after done=%b busy=%b want 0 0", done3, busy3);
        end
        mode = 2'b00;
    endtask

    task automatic test_overflow();
        go_idle_clear();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
        end
        n_cmp++; if (count3 !== 5'd16 || ovf3 !== 1'b0) begin
            n_err++; $display("FAIL ovf_full count=%0d ovf=%b want 16 0", count3, ovf3);
        end
        tick();
        wr_en = 1'b0;
        n_cmp++; if (count3 !== 5'd16 || ovf3 !== 1'b1) begin
            n_err++; $display("FAIL ovf_set count=%0d ovf=%b want 16 1", count3, ovf3);
        end
        clr = 1'b1; wr_en = 1'b1; tick(); clr = 1'b0; wr_en = 1'b0;
        n_cmp++; if (count3 !== 5'd0 || ovf3 !== 1'b0) begin
            n_err++; $display("FAIL ovf_clr count=%0d ovf=%b want 0 0", count3, ovf3);
        end
        pulse_start();
        n_cmp++; if (done3 !== 1'b1 || busy3 !== 1'b0) begin
            n_err++; $display("FAIL empty_start done=%b busy=%b want 1 0", done3, busy3);
        end
        tick();
        n_cmp++; if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            n_err++; $display("FAIL empty_after done=%b busy=%b want 0 0", done3, busy3);
        end
    endtask

    task automatic test_async_reset();
        go_idle_clear();
        prog[0] = 8'h04; prog[1] = 8'h00; prog[2] = 8'h13; prog[3] = 8'h92;
        load_prog(4);
        mode = 2'b00; rdy3 = 1'b0; rdy0 = 1'b0;
        pulse_start();
        tick();
        n_cmp++; if (vld3 !== 1'b1) begin n_err++; $display("FAIL rst_pre vld got %b want 1", vld3); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (vld3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0 || wd3 !== 8'h00) begin
            n_err++; $display("FAIL rst_async vld=%b busy=%b done=%b wd=%h want 0 0 0 00", vld3, busy3, done3, wd3);
        end
        n_cmp++; if (count3 !== 5'd0 || ptr3 !== 4'd0 || ovf3 !== 1'b0) begin
            n_err++; $display("FAIL rst_async_regs count=%0d ptr=%0d ovf=%b want 0 0 0", count3, ptr3, ovf3);
        end
        #1 rst = 1'b0;
        tick();
        load_prog(4);
        rdy3 = 1'b1;
        pulse_start();
        tick();
        n_cmp++; if (vld3 !== 1'b1 || wd3 !== 8'h04 || ptr3 !== 4'd0) begin
            n_err++; $display("FAIL rst_replay vld=%b wd=%h ptr=%0d want 1 04 0", vld3, wd3, ptr3);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr = 1'b0; start = 1'b0;
        step = 1'b0; abort = 1'b0; mode = 2'b00; rdy3 = 1'b1; rdy0 = 1'b1;
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_run_gap();
        test_stall();
        test_step();
        test_loop_abort();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
